// File: rtl/board_game_ctrl_pkg.sv
// Shared types and helpers for the N x N K-in-a-row game engine.
package game_pkg;

    localparam int MAX_CELLS = 64;

    typedef enum logic [2:0] {
        PLAYING = 3'd0,
        X_WIN   = 3'd1,
        O_WIN   = 3'd2,
        DRAW    = 3'd3,
        WAIT_AI = 3'd4
    } status_e;

    typedef enum logic [1:0] {
        S_TURN    = 2'd0,
        S_AI_WAIT = 2'd1,
        S_CHECK   = 2'd2,
        S_OVER    = 2'd3
    } fsm_e;

    function automatic int cell_idx(input int row, input int col, input int n);
        return row * n + col;
    endfunction

    // Scans downward so the last hit is the lowest free index; callers never pass a full board.
    function automatic int lowest_free(input logic [MAX_CELLS-1:0] bitmap, input int ncells);
        int idx;
        idx = 0;
        for (int i = MAX_CELLS - 1; i >= 0; i--) begin
            if (i < ncells && !bitmap[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/board_game_ctrl_win_detect.sv
// Combinational K-in-a-row detector over one player's occupancy bitmap.
module win_detect
    import game_pkg::*;
#(
    parameter int N       = 3,
    parameter int WIN_LEN = 3
) (
    input  logic [N*N-1:0] bitmap,
    output logic           win
);

    logic [N*N-1:0] row_hit;
    logic [N*N-1:0] col_hit;
    logic [N*N-1:0] dia_hit;
    logic [N*N-1:0] ant_hit;

    // Each cell is the anchor of at most one window per direction.
    for (genvar r = 0; r < N; r++) begin : g_r
        for (genvar c = 0; c < N; c++) begin : g_c
            localparam int BASE = r * N + c;

            if (c <= N - WIN_LEN) begin : g_h
                logic [WIN_LEN-1:0] run;
                for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
                    assign run[k] = bitmap[cell_idx(r, c + k, N)];
                end
                assign row_hit[BASE] = &run;
            end else begin : g_nh
                assign row_hit[BASE] = 1'b0;
            end

            if (r <= N - WIN_LEN) begin : g_v
                logic [WIN_LEN-1:0] run;
                for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
                    assign run[k] = bitmap[cell_idx(r + k, c, N)];
                end
                assign col_hit[BASE] = &run;
            end else begin : g_nv
                assign col_hit[BASE] = 1'b0;
            end

            if (r <= N - WIN_LEN && c <= N - WIN_LEN) begin : g_d
                logic [WIN_LEN-1:0] run;
                for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
                    assign run[k] = bitmap[cell_idx(r + k, c + k, N)];
                end
                assign dia_hit[BASE] = &run;
            end else begin : g_nd
                assign dia_hit[BASE] = 1'b0;
            end

            if (r <= N - WIN_LEN && c >= WIN_LEN - 1) begin : g_a
                logic [WIN_LEN-1:0] run;
                for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
                    assign run[k] = bitmap[cell_idx(r + k, c - k, N)];
                end
                assign ant_hit[BASE] = &run;
            end else begin : g_na
                assign ant_hit[BASE] = 1'b0;
            end
        end
    end

    assign win = |{row_hit, col_hit, dia_hit, ant_hit};

endmodule

// File: rtl/board_game_ctrl.sv
// Game-state engine: captures human/AI moves, validates them, alternates turns
// and reports win/draw, advancing only on logic-enable ticks.
module board_game_ctrl
    import game_pkg::*;
#(
    parameter  int N       = 3,
    parameter  int WIN_LEN = 3,
    localparam int IDXW    = $clog2(N * N)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            tick,
    input  logic            new_game,
    input  logic            move_req,
    input  logic [IDXW-1:0] move_idx,
    input  logic            ai_en,
    input  logic            ai_valid,
    input  logic [N*N-1:0]  ai_move,
    output logic [N*N-1:0]  x_state,
    output logic [N*N-1:0]  o_state,
    output logic [2:0]      status,
    output logic            player,
    output logic            move_ack,
    output logic            move_err
);

    localparam int             NN        = N * N;
    localparam logic [NN-1:0]  CELL_ZERO = {NN{1'b0}};
    localparam logic [NN-1:0]  CELL_ONE  = {{(NN-1){1'b0}}, 1'b1};

    logic [NN-1:0]   x_q, x_d, o_q, o_d;
    status_e         status_q, status_d;
    fsm_e            fsm_q, fsm_d;
    logic            player_q, player_d;
    logic            ack_q, ack_d, err_q, err_d;
    logic            pending_q, pending_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [NN-1:0]   occ_s, req_oh_s, ai_oh_s, mover_s;
    logic            idx_bad_s, req_ok_s, ai_ok_s, win_s, consume_s;

    assign occ_s     = x_q | o_q;
    assign req_oh_s  = CELL_ONE << idx_q;
    assign idx_bad_s = ({1'b0, idx_q} >= (IDXW + 1)'(NN));
    assign req_ok_s  = !idx_bad_s && ((req_oh_s & occ_s) == CELL_ZERO) && !(player_q && ai_en);
    assign ai_ok_s   = (ai_move != CELL_ZERO) && ((ai_move & (ai_move - CELL_ONE)) == CELL_ZERO)
                       && ((ai_move & occ_s) == CELL_ZERO);
    assign ai_oh_s   = ai_ok_s ? ai_move : (CELL_ONE << lowest_free(MAX_CELLS'(occ_s), NN));
    assign mover_s   = player_q ? o_q : x_q;
    // A request landing during CHECK waits for the following TURN/AI_WAIT tick.
    assign consume_s = pending_q && (fsm_q != S_CHECK);

    win_detect #(.N(N), .WIN_LEN(WIN_LEN)) u_win (
        .bitmap (mover_s),
        .win    (win_s)
    );

    // Request capture: a fresh move_req outranks consumption of the previous one.
    always_comb begin
        if (move_req && !(tick && new_game)) begin
            pending_d = 1'b1;
            idx_d     = move_idx;
        end else if (tick && (new_game || consume_s)) begin
            pending_d = 1'b0;
            idx_d     = idx_q;
        end else begin
            pending_d = pending_q;
            idx_d     = idx_q;
        end
    end

    // Game FSM next-state and board update.
    always_comb begin
        x_d      = x_q;
        o_d      = o_q;
        status_d = status_q;
        player_d = player_q;
        fsm_d    = fsm_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        if (tick && new_game) begin
            x_d      = CELL_ZERO;
            o_d      = CELL_ZERO;
            status_d = PLAYING;
            player_d = 1'b0;
            fsm_d    = S_TURN;
        end else if (tick) begin
            case (fsm_q)
                S_TURN: begin
                    if (pending_q && req_ok_s) begin
                        if (player_q) begin
                            o_d = o_q | req_oh_s;
                        end else begin
                            x_d = x_q | req_oh_s;
                        end
                        ack_d = 1'b1;
                        fsm_d = S_CHECK;
                    end else begin
                        err_d = pending_q;
                    end
                end
                S_AI_WAIT: begin
                    err_d = pending_q;
                    if (ai_valid) begin
                        o_d   = o_q | ai_oh_s;
                        ack_d = 1'b1;
                        fsm_d = S_CHECK;
                    end else begin
                        fsm_d = S_AI_WAIT;
                    end
                end
                S_CHECK: begin
                    if (win_s) begin
                        status_d = player_q ? O_WIN : X_WIN;
                        fsm_d    = S_OVER;
                    end else if (&occ_s) begin
                        status_d = DRAW;
                        fsm_d    = S_OVER;
                    end else begin
                        player_d = ~player_q;
                        if (!player_q && ai_en) begin
                            status_d = WAIT_AI;
                            fsm_d    = S_AI_WAIT;
                        end else begin
                            status_d = PLAYING;
                            fsm_d    = S_TURN;
                        end
                    end
                end
                S_OVER: begin
                    err_d = pending_q;
                end
                default: begin
                    fsm_d = S_TURN;
                end
            endcase
        end else begin
            fsm_d = fsm_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            x_q       <= CELL_ZERO;
            o_q       <= CELL_ZERO;
            status_q  <= PLAYING;
            fsm_q     <= S_TURN;
            player_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
            idx_q     <= {IDXW{1'b0}};
        end else begin
            x_q       <= x_d;
            o_q       <= o_d;
            status_q  <= status_d;
            fsm_q     <= fsm_d;
            player_q  <= player_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
        end
    end

    assign x_state  = x_q;
    assign o_state  = o_q;
    assign status   = status_q;
    assign player   = player_q;
    assign move_ack = ack_q;
    assign move_err = err_q;

endmodule

// File: tb/tb_board_game_ctrl.sv
// Randomised and directed bench for board_game_ctrl (3x3/K=3 and 5x5/K=4 instances).
module tb_board_game_ctrl;

    logic        clk = 1'b0;
    logic        clr, tick, new_game, move_req, ai_en, ai_valid;
    logic [4:0]  move_idx;
    logic [24:0] ai_move;

    logic [8:0]  a_x, a_o;
    logic [2:0]  a_status;
    logic        a_player, a_ack, a_err;
    logic [24:0] b_x, b_o;
    logic [2:0]  b_status;
    logic        b_player, b_ack, b_err;

    int tests_run    = 0;
    int tests_failed = 0;

    board_game_ctrl #(.N(3), .WIN_LEN(3)) dut_a (
        .clk(clk), .clr(clr), .tick(tick), .new_game(new_game),
        .move_req(move_req), .move_idx(move_idx[3:0]), .ai_en(ai_en),
        .ai_valid(ai_valid), .ai_move(ai_move[8:0]),
        .x_state(a_x), .o_state(a_o), .status(a_status), .player(a_player),
        .move_ack(a_ack), .move_err(a_err)
    );

    board_game_ctrl #(.N(5), .WIN_LEN(4)) dut_b (
        .clk(clk), .clr(clr), .tick(tick), .new_game(new_game),
        .move_req(move_req), .move_idx(move_idx), .ai_en(ai_en),
        .ai_valid(ai_valid), .ai_move(ai_move),
        .x_state(b_x), .o_state(b_o), .status(b_status), .player(b_player),
        .move_ack(b_ack), .move_err(b_err)
    );

    always #5 clk = ~clk;

    // Reference model: board of 0=empty, 1=X, 2=O plus game-level flags.
    int mb[64];
    bit m_player;
    int m_status;
    bit m_over;
    bit m_wait;

    task automatic model_new();
        for (int i = 0; i < 64; i++) mb[i] = 0;
        m_player = 1'b0;
        m_status = 0;
        m_over   = 1'b0;
        m_wait   = 1'b0;
    endtask

    function automatic bit m_wins(input int who, input int n, input int k);
        int dr[4] = '{0, 1, 1, 1};
        int dc[4] = '{1, 0, 1, -1};
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int d = 0; d < 4; d++) begin
                    bit ok = 1'b1;
                    for (int s = 0; s < k; s++) begin
                        int rr = r + dr[d] * s;
                        int cc = c + dc[d] * s;
                        if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
                        else if (mb[rr * n + cc] != who) ok = 1'b0;
                    end
                    if (ok) return 1'b1;
                end
        return 1'b0;
    endfunction

    function automatic logic [24:0] m_bits(input int who, input int n);
        logic [24:0] r = 25'd0;
        for (int i = 0; i < n * n; i++) if (mb[i] == who) r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit m_legal(input int idx, input int n);
        return !m_over && !m_wait && idx < n * n && mb[idx] == 0 && !(m_player && ai_en);
    endfunction

    task automatic model_check(input int n, input int k);
        bit full = 1'b1;
        for (int i = 0; i < n * n; i++) if (mb[i] == 0) full = 1'b0;
        if (m_wins(m_player ? 2 : 1, n, k)) begin
            m_status = m_player ? 2 : 1;
            m_over   = 1'b1;
        end else if (full) begin
            m_status = 3;
            m_over   = 1'b1;
        end else begin
            m_player = !m_player;
            m_wait   = m_player && ai_en;
            m_status = m_wait ? 4 : 0;
        end
    endtask

    function automatic int m_ai_cell(input logic [8:0] am);
        if ($countones(am) == 1) begin
            for (int i = 0; i < 9; i++) if (am[i] && mb[i] == 0) return i;
        end
        for (int i = 0; i < 9; i++) if (mb[i] == 0) return i;
        return 0;
    endfunction

    task automatic pulse_req(input int idx);
        move_idx = 5'(idx);
        move_req = 1'b1;
        @(posedge clk); #1;
        move_req = 1'b0;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic start_game();
        new_game = 1'b1;
        tick_once();
        new_game = 1'b0;
        model_new();
    endtask

    // Drives one human move (and the CHECK tick if the model deems it legal).
    task automatic play_human(input int idx, input int n, input int k, output bit legal,
                              output logic [1:0] ae_a, output logic [1:0] ae_b);
        legal = m_legal(idx, n);
        pulse_req(idx);
        tick_once();
        ae_a = {a_ack, a_err};
        ae_b = {b_ack, b_err};
        if (legal) begin
            mb[idx] = m_player ? 2 : 1;
            tick_once();
            model_check(n, k);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        #2;
        tests_run++;
        if ({a_x, a_o, a_status, a_player, a_ack, a_err} !== 25'd0) begin
            tests_failed++;
            $display("FAIL reset_a: got x=%h o=%h st=%0d pl=%b ack=%b err=%b, expected all zero",
                     a_x, a_o, a_status, a_player, a_ack, a_err);
        end
        tests_run++;
        if ({b_x, b_o, b_status, b_player, b_ack, b_err} !== 57'd0) begin
            tests_failed++;
            $display("FAIL reset_b: got x=%h o=%h st=%0d pl=%b, expected all zero",
                     b_x, b_o, b_status, b_player);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        model_new();
    endtask

    task automatic test_x_win();
        int mv[5] = '{0, 3, 1, 4, 2};
        bit legal;
        logic [1:0] ae_a, ae_b;
        logic [24:0] ex, eo;
        ai_en = 1'b0;
        start_game();
        for (int i = 0; i < 5; i++) begin
            play_human(mv[i], 3, 3, legal, ae_a, ae_b);
            tests_run++;
            if (ae_a !== {legal, !legal}) begin
                tests_failed++;
                $display("FAIL xwin_ack[%0d]: got ack/err=%b expected %b", i, ae_a, {legal, !legal});
            end
            ex = m_bits(1, 3);
            eo = m_bits(2, 3);
            tests_run++;
            if ({a_x, a_o, a_status, a_player} !== {ex[8:0], eo[8:0], 3'(m_status), m_player}) begin
                tests_failed++;
                $display("FAIL xwin_state[%0d]: got x=%b o=%b st=%0d pl=%b expected x=%b o=%b st=%0d pl=%b",
                         i, a_x, a_o, a_status, a_player, ex[8:0], eo[8:0], m_status, m_player);
            end
        end
        tests_run++;
        if (a_x !== 9'b000000111 || a_status !== 3'd1) begin
            tests_failed++;
            $display("FAIL xwin_final: got x=%b st=%0d expected x=000000111 st=1", a_x, a_status);
        end
        pulse_req(5);
        tick_once();
        tests_run++;
        if ({a_ack, a_err, a_x, a_o, a_status} !== {2'b01, 9'b000000111, 9'b000011000, 3'd1}) begin
            tests_failed++;
            $display("FAIL xwin_over_reject: got ack=%b err=%b x=%b o=%b st=%0d expected err pulse, board frozen",
                     a_ack, a_err, a_x, a_o, a_status);
        end
    endtask

    task automatic test_occupied();
        bit legal;
        logic [1:0] ae_a, ae_b;
        ai_en = 1'b0;
        start_game();
        play_human(4, 3, 3, legal, ae_a, ae_b);
        play_human(4, 3, 3, legal, ae_a, ae_b);
        tests_run++;
        if ({ae_a, a_o, a_player} !== {2'b01, 9'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL occupied_reject: got ack/err=%b o=%b pl=%b expected 01 o=0 pl=1", ae_a, a_o, a_player);
        end
        @(posedge clk); #1;
        tests_run++;
        if (a_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_one_cycle: got err=%b one cycle later expected 0", a_err);
        end
        play_human(0, 3, 3, legal, ae_a, ae_b);
        tests_run++;
        if ({ae_a, a_o, a_x} !== {2'b10, 9'b000000001, 9'b000010000}) begin
            tests_failed++;
            $display("FAIL occupied_retry: got ack/err=%b o=%b x=%b expected 10 o=000000001", ae_a, a_o, a_x);
        end
    endtask

    task automatic test_ai_move();
        ai_en = 1'b1;
        start_game();
        pulse_req(4);
        tick_once();
        tests_run++;
        if ({a_ack, a_status} !== {1'b1, 3'd0}) begin
            tests_failed++;
            $display("FAIL ai_xcommit: got ack=%b st=%0d expected ack=1 st=0", a_ack, a_status);
        end
        mb[4] = 1;
        tick_once();
        model_check(3, 3);
        tests_run++;
        if ({a_status, a_player} !== {3'(m_status), m_player} || a_status !== 3'd4) begin
            tests_failed++;
            $display("FAIL ai_wait: got st=%0d pl=%b expected st=4 pl=1", a_status, a_player);
        end
        ai_move  = 25'b10;
        ai_valid = 1'b1;
        tick_once();
        ai_valid = 1'b0;
        tests_run++;
        if ({a_ack, a_o} !== {1'b1, 9'b000000010}) begin
            tests_failed++;
            $display("FAIL ai_commit: got ack=%b o=%b expected ack=1 o=000000010", a_ack, a_o);
        end
        mb[m_ai_cell(9'b000000010)] = 2;
        tick_once();
        model_check(3, 3);
        tests_run++;
        if ({a_status, a_player} !== {3'(m_status), m_player} || a_status !== 3'd0 || a_player !== 1'b0) begin
            tests_failed++;
            $display("FAIL ai_return: got st=%0d pl=%b expected st=0 pl=0", a_status, a_player);
        end
    endtask

    task automatic test_ai_fallback();
        bit legal;
        logic [1:0] ae_a, ae_b;
        logic [24:0] eo;
        ai_en = 1'b1;
        start_game();
        play_human(0, 3, 3, legal, ae_a, ae_b);
        pulse_req(5);
        tick_once();
        tests_run++;
        if ({a_ack, a_err, a_status} !== {2'b01, 3'd4}) begin
            tests_failed++;
            $display("FAIL ai_human_reject: got ack=%b err=%b st=%0d expected 0 1 4", a_ack, a_err, a_status);
        end
        ai_move  = 25'b11;
        ai_valid = 1'b1;
        tick_once();
        ai_valid = 1'b0;
        mb[m_ai_cell(9'b000000011)] = 2;
        eo = m_bits(2, 3);
        tests_run++;
        if ({a_ack, a_o} !== {1'b1, 9'b000000010} || a_o !== eo[8:0]) begin
            tests_failed++;
            $display("FAIL ai_fallback: got ack=%b o=%b expected ack=1 o=000000010", a_ack, a_o);
        end
        tick_once();
        model_check(3, 3);
    endtask

    task automatic test_draw();
        int mv[9] = '{0, 2, 1, 3, 5, 4, 6, 7, 8};
        bit legal;
        logic [1:0] ae_a, ae_b;
        ai_en = 1'b0;
        start_game();
        for (int i = 0; i < 9; i++) begin
            play_human(mv[i], 3, 3, legal, ae_a, ae_b);
            tests_run++;
            if (ae_a !== 2'b10 || a_status !== 3'(m_status)) begin
                tests_failed++;
                $display("FAIL draw_move[%0d]: got ack/err=%b st=%0d expected 10 st=%0d", i, ae_a, a_status, m_status);
            end
        end
        tests_run++;
        if ({a_status, a_x, a_o} !== {3'd3, 9'b101100011, 9'b010011100}) begin
            tests_failed++;
            $display("FAIL draw_final: got st=%0d x=%b o=%b expected st=3 x=101100011 o=010011100",
                     a_status, a_x, a_o);
        end
        start_game();
        tests_run++;
        if ({a_x, a_o, a_status, a_player, a_ack, a_err} !== 25'd0) begin
            tests_failed++;
            $display("FAIL new_game: got x=%b o=%b st=%0d pl=%b expected all zero", a_x, a_o, a_status, a_player);
        end
    endtask

    task automatic test_n5_diag();
        int mv[7] = '{6, 0, 12, 1, 18, 2, 24};
        bit legal;
        logic [1:0] ae_a, ae_b;
        logic [24:0] ex, eo;
        ai_en = 1'b0;
        start_game();
        for (int i = 0; i < 7; i++) begin
            play_human(mv[i], 5, 4, legal, ae_a, ae_b);
            ex = m_bits(1, 5);
            eo = m_bits(2, 5);
            tests_run++;
            if ({ae_b, b_x, b_o, b_status, b_player} !== {2'b10, ex, eo, 3'(m_status), m_player}) begin
                tests_failed++;
                $display("FAIL n5_move[%0d]: got ack/err=%b x=%h o=%h st=%0d expected x=%h o=%h st=%0d",
                         i, ae_b, b_x, b_o, b_status, ex, eo, m_status);
            end
        end
        tests_run++;
        if ({b_status, b_x} !== {3'd1, 25'h1041040}) begin
            tests_failed++;
            $display("FAIL n5_win: got st=%0d x=%h expected st=1 x=1041040", b_status, b_x);
        end
    endtask

    task automatic test_clr_async();
        bit legal;
        logic [1:0] ae_a, ae_b;
        ai_en = 1'b0;
        start_game();
        pulse_req(6);
        tick_once();
        tests_run++;
        if ({b_ack, b_x} !== {1'b1, 25'h40}) begin
            tests_failed++;
            $display("FAIL clr_setup: got ack=%b x=%h expected ack=1 x=40", b_ack, b_x);
        end
        #2;
        clr = 1'b1;
        #1;
        tests_run++;
        if ({b_x, b_o, b_status, b_player, b_ack, b_err} !== 57'd0) begin
            tests_failed++;
            $display("FAIL clr_async: got x=%h o=%h st=%0d pl=%b ack=%b expected all zero before edge",
                     b_x, b_o, b_status, b_player, b_ack);
        end
        #1;
        clr = 1'b0;
        @(posedge clk); #1;
        model_new();
        play_human(12, 5, 4, legal, ae_a, ae_b);
        tests_run++;
        if ({ae_b, b_x, b_player} !== {2'b10, 25'h1000, 1'b1}) begin
            tests_failed++;
            $display("FAIL clr_resume: got ack/err=%b x=%h pl=%b expected 10 x=1000 pl=1", ae_b, b_x, b_player);
        end
    endtask

    task automatic test_random();
        bit legal;
        logic [1:0] ae_a, ae_b;
        logic [24:0] ex, eo;
        logic [8:0] am;
        bit done;
        for (int g = 0; g < 25; g++) begin
            ai_en = 1'($urandom_range(0, 1));
            start_game();
            done = 1'b0;
            for (int s = 0; s < 30 && !done; s++) begin
                if (m_over) begin
                    pulse_req($urandom_range(0, 15));
                    tick_once();
                    ae_a = {a_ack, a_err};
                    done = 1'b1;
                end else if (m_wait) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pulse_req($urandom_range(0, 15));
                        tick_once();
                        tests_run++;
                        if ({a_ack, a_err} !== 2'b01) begin
                            tests_failed++;
                            $display("FAIL rnd_wait_reject g%0d: got ack/err=%b expected 01", g, {a_ack, a_err});
                        end
                    end
                    if ($urandom_range(0, 1) == 1) am = 9'b1 << $urandom_range(0, 8);
                    else am = 9'($urandom);
                    ai_move  = 25'(am);
                    ai_valid = 1'b1;
                    tick_once();
                    ai_valid = 1'b0;
                    ae_a = {a_ack, a_err};
                    mb[m_ai_cell(am)] = 2;
                    tick_once();
                    model_check(3, 3);
                    legal = 1'b1;
                end else begin
                    play_human($urandom_range(0, 15), 3, 3, legal, ae_a, ae_b);
                end
                if (done) legal = 1'b0;
                tests_run++;
                if (ae_a !== {legal, !legal}) begin
                    tests_failed++;
                    $display("FAIL rnd_ack g%0d s%0d: got ack/err=%b expected %b", g, s, ae_a, {legal, !legal});
                end
                ex = m_bits(1, 3);
                eo = m_bits(2, 3);
                tests_run++;
                if ({a_x, a_o, a_status, a_player} !== {ex[8:0], eo[8:0], 3'(m_status), m_player}) begin
                    tests_failed++;
                    $display("FAIL rnd_state g%0d s%0d: got x=%b o=%b st=%0d pl=%b expected x=%b o=%b st=%0d pl=%b",
                             g, s, a_x, a_o, a_status, a_player, ex[8:0], eo[8:0], m_status, m_player);
                end
                tests_run++;
                if ((a_x & a_o) !== 9'd0) begin
                    tests_failed++;
                    $display("FAIL rnd_overlap g%0d: got x&o=%b expected 0", g, a_x & a_o);
                end
            end
        end
    endtask

    initial begin
        clr      = 1'b0;
        tick     = 1'b0;
        new_game = 1'b0;
        move_req = 1'b0;
        move_idx = 5'd0;
        ai_en    = 1'b0;
        ai_valid = 1'b0;
        ai_move  = 25'd0;
        @(posedge clk); #1;
        test_reset();
        test_x_win();
        test_occupied();
        test_ai_move();
        test_ai_fallback();
        test_draw();
        test_n5_diag();
        test_clr_async();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/board_game_ctrl.md
Name: board_game_ctrl

Overview:
- Parametrised game-state engine for N x N "K-in-a-row" boards; the successor to the fixed 3x3 tic-tac-toe state block.
- Accepts human moves from the debounced input path and optional AI moves from an external move generator.
- Validates each move, alternates turns, and detects win/draw.
- Publishes X/O occupancy bitmaps and status to the VGA renderer.
- All state advances only on logic-enable ticks.

Parameters:
- N, 3: board dimension (legal range 3..8); board has N*N cells, cell index = row*N + col.
- WIN_LEN, 3: run length needed to win (3..N); checked on rows, columns, both diagonals.
- IDXW, derived as clog2(N*N): width of the move index; local, not overridable.

Ports:
- clk  in  1  system clock
- clr  in  1  reset
- tick  in  1  logic enable; state updates only on cycles with tick=1
- new_game  in  1  synchronous restart, sampled on tick
- move_req  in  1  one-cycle pulse from the debouncer; may arrive on any cycle
- move_idx  in  IDXW  human cell index, sampled with move_req
- ai_en  in  1  1 = O is played by the AI, 0 = two-player
- ai_valid  in  1  ai_move is meaningful
- ai_move  in  N*N  proposed O move, one-hot
- x_state  out  N*N  X occupancy bitmap
- o_state  out  N*N  O occupancy bitmap
- status  out  3  game status, codes in package
- player  out  1  side to move: 0 = X, 1 = O
- move_ack  out  1  one-cycle pulse when a move is committed
- move_err  out  1  one-cycle pulse when a move is rejected

Behaviour:
- Reset is clr, asynchronous, active-high; clock is clk.
- Reset values: x_state=0, o_state=0, status=PLAYING (0), player=0, move_ack=0, move_err=0, pending=0, FSM=TURN.
- Request capture:
  - move_req sets the pending flag and latches move_idx on any cycle.
  - A second move_req before it is consumed overwrites the index.
  - pending is consumed on the next tick.
- FSM states: TURN, AI_WAIT, CHECK, OVER.
- TURN, on tick with pending:
  - Illegal move (idx >= N*N, cell occupied, or player=1 with ai_en=1): move_err pulses, board and player unchanged, pending cleared.
  - Legal move: the mover's bitmap bit is set, move_ack pulses, FSM goes to CHECK.
- CHECK, next tick:
  - Run win_detect on the mover's bitmap.
  - Win: status = X_WIN or O_WIN, go to OVER.
  - Otherwise, if (x_state | o_state) is all ones: status=DRAW, go to OVER.
  - Otherwise toggle player. Go to AI_WAIT if the new player is 1 and ai_en=1, else TURN.
  - Status is valid exactly one tick after the committing tick.
- AI_WAIT, status=WAIT_AI (4):
  - On tick with ai_valid: if ai_move is one-hot and the cell is free, commit it as O.
  - Otherwise commit O to the lowest-index free cell (fallback).
  - Either way move_ack pulses and FSM goes to CHECK.
  - A human move_req here is rejected on the next tick with move_err.
- OVER:
  - Bitmaps and status frozen.
  - Any pending move is rejected with move_err on tick.
  - Only new_game or clr leaves this state.
- new_game on tick, from any state: bitmaps cleared, player=0, status=PLAYING, pending cleared, FSM=TURN. new_game has priority over a simultaneous move.
- ai_en changed mid-game takes effect at the next CHECK.
- Invariant: x_state & o_state == 0 at all times.
- Outputs are registered; move_ack and move_err are each high for exactly one clk cycle.

Decomposition:
- Shared package game_pkg:
  - status codes PLAYING=0, X_WIN=1, O_WIN=2, DRAW=3, WAIT_AI=4
  - FSM state enum
  - function cell_idx(row,col)
  - function lowest_free(bitmap)
- Sub-module win_detect:
  - purely combinational; parameters N, WIN_LEN
  - input bitmap N*N, output win
  - generate loops over all row, column, diagonal and anti-diagonal windows of length WIN_LEN
  - instantiated once, muxed on the mover's bitmap

Test Plan:
- N=3, ai_en=0. X plays 0, O plays 3, X plays 1, O plays 4, X plays 2 (tick between each). Required: x_state=9'b000000111, status=X_WIN one tick after the last move_ack; a further move_req gives move_err, board unchanged.
- N=3. X plays 4, then O requests 4. Required: move_err pulse, o_state=0, player stays 1; O then plays 0 and gets move_ack.
- N=3, ai_en=1. X plays 4, then ai_move=9'b000000010 with ai_valid. Required: o_state=9'b000000010, status walks PLAYING -> WAIT_AI -> PLAYING, player returns to 0.
- N=3, ai_en=1. X holds cell 0; ai_move=9'b000000011 (not one-hot). Required: fallback commits O at cell 1 (lowest free cell).
- N=3. Fill the board with no three-in-a-row, e.g. X{0,1,5,6,8}, O{2,3,4,7}. Required: status=DRAW after the ninth move. Then new_game: all outputs at reset values on the next tick.
- N=5, WIN_LEN=4, ai_en=0. X plays 6, 12, 18, 24 on the diagonal, O plays 0, 1, 2. Required: X_WIN after X's fourth move. Separately, assert clr mid-CHECK: outputs clear immediately, without waiting for a clock edge.
